fifo_rd_packer: RTL and testbench

//  Read-domain stage directly downstream of the async FIFO; runs entirely on Rd_clk.

---
 rtl/fifo_rd_packer_if.sv | 18 +
 rtl/fifo_rd_packer.sv | 60 ++++++
 tb/tb_fifo_rd_packer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if: FIFO read-side input handshake, flush request and packed output handshake
//   slave  - packer side: takes In_*/Flush/Out_ready, drives In_ready and Out_*
//   master - environment side: the opposite directions
interface fifo_rd_packer_if #(parameter int WIDTH = 4, parameter int PACK = 4);
  logic [WIDTH-1:0]         In_data;
  logic                     In_valid;
  logic                     In_ready;
  logic                     Flush;
  logic [WIDTH*PACK-1:0]    Out_data;
  logic                     Out_valid;
  logic                     Out_ready;
  logic                     Out_last;
  logic [$clog2(PACK+1)-1:0] Out_cnt;
  modport slave (input In_data, In_valid, Flush, Out_ready,
                 output In_ready, Out_data, Out_valid, Out_last, Out_cnt);
  modport master (output In_data, In_valid, Flush, Out_ready,
                  input In_ready, Out_data, Out_valid, Out_last, Out_cnt);
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: packs PACK consecutive WIDTH-bit FIFO words into one output word, first word in the LSB lane
//   Rd_clk/reset - single clock, synchronous active-high reset
//   bus          - In_* pop handshake, Flush request, Out_* packed word with lane count and last flag
module fifo_rd_packer #(parameter int WIDTH = 4, parameter int PACK = 4) (
  input logic              Rd_clk,
  input logic              reset,
  fifo_rd_packer_if.slave  bus
);
  localparam int WP = WIDTH * PACK;
  localparam int CW = $clog2(PACK + 1);
  localparam logic [CW-1:0] LAST = CW'(PACK - 1);
  logic [WP-1:0] acc_q, acc_d, acc_new, out_data_q, out_data_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d, cnt_new, out_cnt_q, out_cnt_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d, flush_pend_q, flush_pend_d;
  logic out_free, in_ready, fire, complete, flush_req, has_data, emit;
  always_comb begin
    out_free = !out_valid_q || bus.Out_ready;
    // only the lane-completing word needs room in the output register
    in_ready = !flush_pend_q && (acc_cnt_q < LAST || out_free);
    fire = bus.In_valid && in_ready;
    acc_new = acc_q | (fire ? WP'(bus.In_data) << (acc_cnt_q * WIDTH) : '0);
    cnt_new = acc_cnt_q + CW'(fire);
    complete = fire && acc_cnt_q == LAST;
    flush_req = bus.Flush || flush_pend_q;
    has_data = cnt_new != '0;
    // a completing word always has out_free, since in_ready required it
    emit = complete || (flush_req && has_data && out_free);
    flush_pend_d = flush_req && has_data && !out_free;
    acc_d = emit ? '0 : acc_new;
    acc_cnt_d = emit ? '0 : cnt_new;
    out_valid_d = emit || (out_valid_q && !bus.Out_ready);
    out_data_d = emit ? acc_new : out_data_q;
    out_cnt_d = emit ? cnt_new : out_cnt_q;
    out_last_d = emit ? flush_req : out_last_q;
  end
  always_ff @(posedge Rd_clk) begin
    if (reset) begin
      acc_q <= '0;
      acc_cnt_q <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_cnt_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_cnt_q <= out_cnt_d;
      out_last_q <= out_last_d;
    end
  end
  assign bus.In_ready = in_ready;
  assign bus.Out_data = out_data_q;
  assign bus.Out_valid = out_valid_q;
  assign bus.Out_cnt = out_cnt_q;
  assign bus.Out_last = out_last_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed stimulus with a queue scoreboard checked by an output monitor
module tb_fifo_rd_packer;
  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  c;
    logic        l;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int pass_cnt = 0;
  int tot_cnt = 0;
  exp_t exp_q[$];
  fifo_rd_packer_if #(.WIDTH(4), .PACK(4)) bus ();
  fifo_rd_packer #(.WIDTH(4), .PACK(4)) dut (.Rd_clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tot_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask
  task automatic push(input logic [15:0] d, input logic [2:0] c, input logic l);
    exp_q.push_back('{d: d, c: c, l: l});
  endtask
  task automatic step;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [3:0] d, input logic rdy);
    bus.In_valid = 1'b1;
    bus.In_data = d;
    bus.Flush = 1'b0;
    @(negedge clk);
    chk($sformatf("in_ready_%0h", d), 32'(bus.In_ready), 32'(rdy));
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.In_valid = 1'b0;
    bus.Flush = 1'b0;
    step();
  endtask
  task automatic flush;
    bus.In_valid = 1'b0;
    bus.Flush = 1'b1;
    step();
    bus.Flush = 1'b0;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.Out_valid && bus.Out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(bus.Out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(bus.Out_data), 32'(e.d));
          chk("out_cnt", 32'(bus.Out_cnt), 32'(e.c));
          chk("out_last", 32'(bus.Out_last), 32'(e.l));
        end
      end
    end
  end
  initial begin
    reset = 1'b1;
    bus.In_valid = 1'b0;
    bus.In_data = '0;
    bus.Flush = 1'b0;
    bus.Out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", 32'(bus.Out_valid), 0);
    chk("rst_data", 32'(bus.Out_data), 0);
    chk("rst_cnt", 32'(bus.Out_cnt), 0);
    chk("rst_last", 32'(bus.Out_last), 0);
    chk("rst_in_ready", 32'(bus.In_ready), 1);
    // single full word
    push(16'h4321, 3'd4, 1'b0);
    for (int i = 1; i <= 4; i++) put(4'(i), 1'b1);
    chk("t1_valid", 32'(bus.Out_valid), 1);
    chk("t1_data", 32'(bus.Out_data), 32'h4321);
    idle();
    // back-to-back stream
    push(16'h4321, 3'd4, 1'b0);
    push(16'h8765, 3'd4, 1'b0);
    for (int i = 1; i <= 8; i++) put(4'(i), 1'b1);
    idle();
    idle();
    // output stall: completing word blocked until the held word drains
    push(16'h4321, 3'd4, 1'b0);
    for (int i = 1; i <= 4; i++) put(4'(i), 1'b1);
    bus.Out_ready = 1'b0;
    put(4'h5, 1'b1);
    put(4'h6, 1'b1);
    put(4'h7, 1'b1);
    put(4'h8, 1'b0);
    put(4'h8, 1'b0);
    chk("t3_hold_valid", 32'(bus.Out_valid), 1);
    chk("t3_hold_data", 32'(bus.Out_data), 32'h4321);
    push(16'h8765, 3'd4, 1'b0);
    bus.Out_ready = 1'b1;
    put(4'h8, 1'b1);
    chk("t3_next_valid", 32'(bus.Out_valid), 1);
    chk("t3_next_data", 32'(bus.Out_data), 32'h8765);
    idle();
    // flush of a two-lane partial word
    push(16'h00BA, 3'd2, 1'b1);
    put(4'hA, 1'b1);
    put(4'hB, 1'b1);
    flush();
    chk("t4_acc_cnt", 32'(dut.acc_cnt_q), 0);
    chk("t4_last", 32'(bus.Out_last), 1);
    idle();
    // flush while output is blocked becomes pending
    push(16'h4321, 3'd4, 1'b0);
    for (int i = 1; i <= 4; i++) put(4'(i), 1'b1);
    bus.Out_ready = 1'b0;
    put(4'hC, 1'b1);
    flush();
    chk("t5_pend", 32'(dut.flush_pend_q), 1);
    chk("t5_in_ready", 32'(bus.In_ready), 0);
    idle();
    chk("t5_pend_held", 32'(dut.flush_pend_q), 1);
    push(16'h000C, 3'd1, 1'b1);
    bus.Out_ready = 1'b1;
    idle();
    chk("t5_pend_clr", 32'(dut.flush_pend_q), 0);
    chk("t5_data", 32'(bus.Out_data), 32'h000C);
    idle();
    // reset discards the held word and the partial accumulator
    bus.Out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) put(4'(i), 1'b1);
    put(4'h5, 1'b1);
    put(4'h6, 1'b1);
    put(4'h7, 1'b1);
    bus.In_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_valid", 32'(bus.Out_valid), 0);
    chk("t6_data", 32'(bus.Out_data), 0);
    chk("t6_cnt", 32'(bus.Out_cnt), 0);
    chk("t6_last", 32'(bus.Out_last), 0);
    chk("t6_in_ready", 32'(bus.In_ready), 1);
    chk("t6_acc_cnt", 32'(dut.acc_cnt_q), 0);
    bus.Out_ready = 1'b1;
    push(16'hCBA9, 3'd4, 1'b0);
    put(4'h9, 1'b1);
    put(4'hA, 1'b1);
    put(4'hB, 1'b1);
    put(4'hC, 1'b1);
    idle();
    idle();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
